glb_stream_reader: RTL and testbench

Global-buffer read streamer for one PE data channel: weight, feature or psum-in. It sits directly upstream of `pe_top`. It holds a preloadable 1R1W on-chip buffer and accepts a (start address, length, stride) command. It streams the addressed words onto the PE bus one word per cycle, gated by the PE's load-ready signal. It pulses `done` with the last word. One instance is placed per channel.

---
 rtl/glb_pkg.sv | 19 +
 rtl/glb_stream_reader_if.sv | 38 +++
 rtl/glb_sram_1r1w.sv | 41 ++++
 rtl/glb_stream_reader.sv | 157 +++++++++++++++
 tb/tb_glb_stream_reader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_pkg.sv
// Shared definitions for the global-buffer channel readers: FSM encoding and
// default geometry of one channel buffer.
package glb_pkg;

  localparam int GLB_DATA_WIDTH = 16;
  localparam int GLB_DEPTH      = 102;
  localparam int GLB_LEN_WIDTH  = 8;

  localparam logic [1:0] GLB_ST_IDLE   = 2'd0;
  localparam logic [1:0] GLB_ST_STREAM = 2'd1;
  localparam logic [1:0] GLB_ST_DRAIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = GLB_ST_IDLE,
    ST_STREAM = GLB_ST_STREAM,
    ST_DRAIN  = GLB_ST_DRAIN
  } glb_state_e;

endpackage

// File: rtl/glb_stream_reader_if.sv
// Preload, command and PE-bus signals of one global-buffer read channel.
// master = the side issuing commands and preloads, slave = the reader.
interface glb_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 8
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] cmd_stride;
  logic                  pe_load_ready;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_valid;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output cmd_valid, cmd_addr, cmd_len, cmd_stride,
    output pe_load_ready,
    input  cmd_ready, bus_data, bus_valid, busy, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  cmd_valid, cmd_addr, cmd_len, cmd_stride,
    input  pe_load_ready,
    output cmd_ready, bus_data, bus_valid, busy, done, err
  );

endinterface

// File: rtl/glb_sram_1r1w.sv
// Synchronous 1R1W buffer, read-first on same-address collision. Read data is
// registered and only updates on a read, so it holds between reads.
module glb_sram_1r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 102,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage write port; out-of-range addresses are dropped, contents never reset.
  always_ff @(posedge clk) begin
    if (we_i && ({1'b0, waddr_i} < DEPTH_EXT)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; non-blocking update gives old data on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/glb_stream_reader.sv
// Global-buffer read streamer for one PE channel: accepts (addr, len, stride)
// and issues one buffer read per cycle the PE can absorb a word, wrapping the
// address modulo DEPTH. Each issued word appears on the bus the next cycle.
module glb_stream_reader
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = GLB_DATA_WIDTH,
  parameter int DEPTH      = GLB_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = GLB_LEN_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  glb_stream_reader_if.slave bus_if
);

  localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  glb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  bus_valid_q, bus_valid_d;

  logic                  accept_s;
  logic                  cmd_illegal_s;
  logic                  cmd_empty_s;
  logic                  issue_s;
  logic [ADDR_WIDTH:0]   addr_sum_s;
  logic [ADDR_WIDTH:0]   addr_wrap_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign accept_s      = bus_if.cmd_valid & cmd_ready_q & (state_q == ST_IDLE);
  assign cmd_illegal_s = ({1'b0, bus_if.cmd_addr} >= DEPTH_EXT) ||
                         ({1'b0, bus_if.cmd_stride} >= DEPTH_EXT);
  assign cmd_empty_s   = (bus_if.cmd_len == {LEN_WIDTH{1'b0}});

  // Next stream address; both operands are below DEPTH, so one subtraction wraps it.
  always_comb begin
    addr_sum_s  = {1'b0, cur_addr_q} + {1'b0, stride_q};
    addr_wrap_s = addr_sum_s - DEPTH_EXT;
    if (addr_sum_s >= DEPTH_EXT) begin
      addr_next_s = addr_wrap_s[ADDR_WIDTH-1:0];
    end else begin
      addr_next_s = addr_sum_s[ADDR_WIDTH-1:0];
    end
  end

  // Controller: command decode, read issue, counters and output next-state.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cur_addr_d  = bus_if.cmd_addr;
          stride_d    = bus_if.cmd_stride;
          remaining_d = bus_if.cmd_len;
          if (cmd_illegal_s) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd_empty_s) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (bus_if.pe_load_ready) begin
          issue_s     = 1'b1;
          cur_addr_d  = addr_next_s;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            // Last word: done is registered alongside its bus_valid.
            state_d = ST_DRAIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    bus_valid_d = issue_s;
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= {ADDR_WIDTH{1'b0}};
      stride_q    <= {ADDR_WIDTH{1'b0}};
      remaining_q <= {LEN_WIDTH{1'b0}};
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  glb_sram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus_if.wr_en),
    .waddr_i (bus_if.wr_addr),
    .wdata_i (bus_if.wr_data),
    .re_i    (issue_s),
    .raddr_i (cur_addr_q),
    .rdata_o (rd_data_s)
  );

  assign bus_if.cmd_ready = cmd_ready_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;
  assign bus_if.bus_valid = bus_valid_q;
  assign bus_if.bus_data  = rd_data_s;

endmodule

// File: tb/tb_glb_stream_reader.sv
// Bench for glb_stream_reader: directed scenarios plus randomized commands,
// ready patterns and background writes, checked against an array model of the
// buffer with word addresses computed as (addr + k*stride) mod DEPTH.
module tb_glb_stream_reader;

  localparam int DW    = 16;
  localparam int DEPTH = 102;
  localparam int AW    = 7;
  localparam int LW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  glb_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bif ();

  glb_stream_reader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bif)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem_m [0:DEPTH-1];
  logic [DW-1:0] last_data;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bif.wr_en = 1'b0; bif.wr_addr = '0; bif.wr_data = '0;
    bif.cmd_valid = 1'b0; bif.cmd_addr = '0; bif.cmd_len = '0; bif.cmd_stride = '0;
    bif.pe_load_ready = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bif.wr_en = 1'b1; bif.wr_addr = AW'(i); bif.wr_data = DW'(i + 1);
      mem_m[i] = DW'(i + 1);
    end
    @(negedge clk);
    bif.wr_en = 1'b0;
  endtask

  // rmode: 0 = ready held 1, 1 = ready toggling 1,0, 2 = random ready.
  // coll_k: word index at which to write 0xBEEF to the address being read.
  // abort_n: assert reset once this many words have been observed (0 = never).
  task automatic run_cmd(input int a, input int l, input int s, input int rmode,
                         input int coll_k, input bit rnd_wr, input int abort_n);
    int issued, c, ka;
    bit exp_v, exp_d, fin, illegal, r;
    logic [DW-1:0] w;
    got_q.delete();
    exp_q.delete();
    illegal = (a >= DEPTH) || (s >= DEPTH);
    @(negedge clk);
    chk("cmd_ready_idle", bif.cmd_ready, 32'd1);
    bif.cmd_valid = 1'b1; bif.cmd_addr = AW'(a); bif.cmd_len = LW'(l);
    bif.cmd_stride = AW'(s); bif.pe_load_ready = 1'b0; bif.wr_en = 1'b0;
    if (illegal || l == 0) begin
      @(negedge clk);
      chk("deg_done", bif.done, 32'd1);
      chk("deg_err", bif.err, {31'd0, illegal});
      chk("deg_valid", bif.bus_valid, 32'd0);
      chk("deg_busy", bif.busy, 32'd0);
      chk("deg_hold", bif.bus_data, last_data);
      bif.cmd_valid = 1'b0;
      @(negedge clk);
      chk("deg_done_fall", bif.done, 32'd0);
      chk("deg_err_fall", bif.err, 32'd0);
      chk("deg_valid2", bif.bus_valid, 32'd0);
      chk("deg_ready", bif.cmd_ready, 32'd1);
      return;
    end
    issued = 0; c = 0; exp_v = 1'b0; exp_d = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      chk("bus_valid", bif.bus_valid, {31'd0, exp_v});
      if (exp_v) begin
        w = exp_q.pop_front();
        chk("bus_data", bif.bus_data, w);
        got_q.push_back(bif.bus_data);
        last_data = w;
      end else begin
        chk("bus_data_hold", bif.bus_data, last_data);
      end
      chk("done", bif.done, {31'd0, exp_d});
      chk("err_stream", bif.err, 32'd0);
      chk("busy_stream", bif.busy, 32'd1);
      chk("cmd_ready_stream", bif.cmd_ready, 32'd0);
      if (exp_d) begin
        fin = 1'b1;
      end else if (abort_n > 0 && got_q.size() == abort_n) begin
        bif.pe_load_ready = 1'b1; bif.cmd_valid = 1'b0; bif.wr_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", bif.bus_valid, 32'd0);
        chk("rst_data", bif.bus_data, 32'd0);
        chk("rst_done", bif.done, 32'd0);
        chk("rst_busy", bif.busy, 32'd0);
        chk("rst_ready", bif.cmd_ready, 32'd0);
        chk("rst_err", bif.err, 32'd0);
        drive_idle();
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("rst_hold_done", bif.done, 32'd0);
          chk("rst_hold_valid", bif.bus_valid, 32'd0);
        end
        rst_n = 1'b1;
        last_data = '0;
        return;
      end else if (c > 4000) begin
        checks++; failures++;
        $error("FAIL stream_timeout observed=%0d words expected=%0d", issued, l);
        fin = 1'b1;
      end else begin
        case (rmode)
          0:       r = 1'b1;
          1:       r = (c % 2 == 0);
          default: r = ($urandom_range(0, 9) < 6);
        endcase
        bif.pe_load_ready = r;
        bif.cmd_valid = $urandom_range(0, 1) == 1;
        bif.cmd_addr = AW'($urandom_range(0, 127));
        bif.cmd_len = LW'($urandom_range(0, 255));
        bif.cmd_stride = AW'($urandom_range(0, 127));
        bif.wr_en = 1'b0;
        exp_v = 1'b0; exp_d = 1'b0;
        if (r && issued < l) begin
          ka = (a + issued * s) % DEPTH;
          exp_q.push_back(mem_m[ka]);
          if (issued == coll_k) begin
            bif.wr_en = 1'b1; bif.wr_addr = AW'(ka); bif.wr_data = 16'hBEEF;
          end
          issued++;
          exp_v = 1'b1;
          exp_d = (issued == l);
        end
        if (!bif.wr_en && rnd_wr && $urandom_range(0, 3) == 0) begin
          bif.wr_en = 1'b1;
          bif.wr_addr = AW'($urandom_range(0, DEPTH - 1));
          bif.wr_data = DW'($urandom_range(0, 65535));
        end
        if (bif.wr_en) mem_m[bif.wr_addr] = bif.wr_data;
        c++;
      end
    end
    bif.cmd_valid = 1'b0; bif.pe_load_ready = 1'b0; bif.wr_en = 1'b0;
    @(negedge clk);
    chk("after_busy", bif.busy, 32'd0);
    chk("after_done", bif.done, 32'd0);
    chk("after_valid", bif.bus_valid, 32'd0);
    chk("after_ready", bif.cmd_ready, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_exp [4];
    int str_exp [5];
    wrap_exp = '{101, 102, 1, 2};
    str_exp  = '{1, 31, 61, 91, 19};
    drive_idle();
    last_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bif.cmd_ready, 32'd0);
    chk("reset_valid", bif.bus_valid, 32'd0);
    chk("reset_data", bif.bus_data, 32'd0);
    chk("reset_busy", bif.busy, 32'd0);
    chk("reset_done", bif.done, 32'd0);
    chk("reset_err", bif.err, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", bif.cmd_ready, 32'd1);

    preload();

    // Basic stream.
    run_cmd(0, 8, 1, 0, -1, 1'b0, 0);
    chk("basic_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("basic_word", got_q[i], i + 1);

    // Back-pressure with ready toggling.
    run_cmd(9, 27, 1, 1, -1, 1'b0, 0);
    chk("bp_count", got_q.size(), 32'd27);
    for (int i = 0; i < 27 && i < got_q.size(); i++) chk("bp_word", got_q[i], i + 10);

    // Address wrap and large stride.
    run_cmd(100, 4, 1, 0, -1, 1'b0, 0);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("wrap_word", got_q[i], wrap_exp[i]);
    run_cmd(0, 5, 30, 0, -1, 1'b0, 0);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("stride_word", got_q[i], str_exp[i]);

    // Degenerate commands.
    run_cmd(5, 0, 1, 0, -1, 1'b0, 0);
    run_cmd(0, 3, 102, 0, -1, 1'b0, 0);
    run_cmd(102, 2, 1, 0, -1, 1'b0, 0);

    // Read/write collision: old value streamed, new value seen later.
    run_cmd(20, 8, 1, 0, 3, 1'b0, 0);
    if (got_q.size() > 3) chk("coll_old", got_q[3], 32'd24);
    else chk("coll_count", got_q.size(), 32'd8);
    run_cmd(23, 1, 1, 0, -1, 1'b0, 0);
    if (got_q.size() > 0) chk("coll_new", got_q[0], 32'hBEEF);
    else chk("coll_new_count", got_q.size(), 32'd1);

    // Reset mid-stream, then a fresh short command.
    run_cmd(0, 8, 1, 0, -1, 1'b0, 3);
    run_cmd(50, 2, 1, 0, -1, 1'b0, 0);
    chk("post_rst_count", got_q.size(), 32'd2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) chk("post_rst_word", got_q[i], i + 51);

    // Randomized commands, ready and background writes.
    for (int t = 0; t < 24; t++) begin
      int ra, rl, rs;
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, DEPTH - 1);
      rs = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, 40);
      run_cmd(ra, rl, rs, 2, -1, 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
